branch_resolve: RTL
===================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, the PC/target width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, the performance-counter width.
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RSTN  in  1  reset, asynchronous, active-low.
REQ-005 if_vld, if_freeze  in  1,1  fetch slot valid; fetch frozen.
REQ-006 if_pc, bp_pc  in  XLEN,XLEN  fetched PC; predicted target.
REQ-007 bp_taken  in  1  predictor taken decision for if_pc.
REQ-008 id_stall, ex_stall  in  1,1  hold the ID or EX stage.
REQ-009 ex_br, ex_jal, ex_jalr  in  1,1,1  EX instruction is a conditional branch, JAL or JALR (one-hot or zero).
REQ-010 ex_cond  in  1  branch comparator result (1 = condition true).
REQ-011 ex_target  in  XLEN  computed jump/branch target.
REQ-012 ex_rd, ex_rs1  in  5,5  destination and source-1 register indices.
REQ-013 alu_branch, alu_call, alu_return, alu_taken, alu_flush  out  1 each  resolution update to the predictor.
REQ-014 alu_pc, alu_target  out  XLEN,XLEN  resolved instruction PC and its actual target.
REQ-015 redirect_pc  out  XLEN  correct next PC, valid only while alu_flush=1.
REQ-016 cnt_clr  in  1  synchronous clear of both counters.
REQ-017 br_cnt, mis_cnt  out  CNT_WIDTH each  resolved control-transfer count; misprediction count.

Function
REQ-018 SHALL carry prediction metadata {vld, pc, taken, target} through two registered stages, ID and EX, in lockstep with the core pipeline.
REQ-019 IF to ID capture: capture when ~id_stall; vld_id <= if_vld & ~if_freeze & ~mis & ~alu_flush.
REQ-020 ID to EX capture: when ~ex_stall, EX <= ID with vld_ex <= vld_id & ~id_stall & ~mis; when ex_stall, EX holds; when id_stall & ~ex_stall, EX receives a bubble (vld_ex=0).
REQ-021 ctl = vld_ex & ~ex_stall & (ex_br|ex_jal|ex_jalr); act_taken = ex_jal|ex_jalr|(ex_br&ex_cond).
REQ-022 mis = ctl & ((act_taken != taken_ex) | (act_taken & taken_ex & ex_target != target_ex)).
REQ-023 link(r) = (r==1)|(r==5); call = (ex_jal|ex_jalr) & link(ex_rd); return = ex_jalr & link(ex_rs1) & ~(link(ex_rd) & ex_rd==ex_rs1).
REQ-024 All alu_* outputs and redirect_pc SHALL be registered: one cycle after the EX cycle with ctl=1, alu_branch=1 for exactly one cycle, with alu_call/alu_return/alu_taken/alu_pc/alu_target from that cycle; otherwise alu_branch=0 and the other alu_* outputs SHALL be 0.
REQ-025 alu_flush SHALL be mis registered, a single-cycle pulse; redirect_pc = act_taken ? ex_target : pc_ex+4, with the sum taken modulo 2^XLEN.
REQ-026 Squash: in the cycle mis=1, ID and EX vld SHALL clear at the next edge. While alu_flush=1, IF capture SHALL be blocked, so that two wrong-path slots are killed.
REQ-027 Back-to-back: a mispredict in the cycle alu_flush=1 is impossible by construction because EX is invalid. The bench SHALL check this condition.
REQ-028 br_cnt SHALL increment on ctl; mis_cnt SHALL increment on mis. Both SHALL saturate at all-ones. cnt_clr SHALL take priority over increment.
REQ-029 Not-taken branch predicted not-taken SHALL produce no flush; the predictor target is then ignored.

Reset
REQ-030 While RSTN=0, all vld bits, all alu_* outputs, redirect_pc, br_cnt and mis_cnt SHALL be 0.
REQ-031 Reset asserted mid-flush SHALL drop alu_flush immediately. After release, the first valid fetch SHALL resolve normally.

Structure
REQ-032 Shared package core_pkg SHALL hold XLEN, register indices RA=1 and T0=5, and the stage-metadata struct.
REQ-033 One sub-module, br_meta_stage, SHALL implement a single stall/flush/bubble metadata register, instantiated twice (ID, EX).

Verification
REQ-034 Predicted taken BEQ at pc 0x100, bp_pc 0x140, ex_cond=1, ex_target=0x140 -> alu_branch=1, alu_taken=1, alu_flush=0, br_cnt=1, mis_cnt=0.
REQ-035 Predicted taken at 0x200, ex_cond=0 -> alu_flush=1 one cycle later, redirect_pc=0x204, next two fetch slots never produce alu_branch, mis_cnt=1.
REQ-036 JAL rd=x1 at 0x300 to 0x400, predicted not-taken -> alu_call=1, alu_return=0, alu_flush=1, redirect_pc=0x400.
REQ-037 JALR rd=x0 rs1=x1 (ret) target 0x304, bp_pc 0x304 taken -> alu_return=1, no flush. JALR rd=x1 rs1=x5 -> alu_call=1, alu_return=1.
REQ-038 ex_stall held 3 cycles over a mispredicting branch -> exactly one alu_branch/alu_flush pulse after the stall releases. id_stall alone -> EX bubble, no update.
REQ-039 Counters preset near all-ones saturate. cnt_clr coincident with a mispredict -> counters read 0. RSTN pulse during alu_flush -> all outputs 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: PC width, link-register indices and the
// prediction metadata carried alongside the pipeline.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] RA = 5'd1;
  localparam logic [4:0] T0 = 5'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } meta_t;

  // x1 and x5 are the registers the return-address stack treats as link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == RA) || (r == T0);
  endfunction

endpackage

// File: rtl/br_meta_stage.sv
// One pipeline register of prediction metadata with stall (hold), flush
// (valid clear) and bubble (load of an invalid slot) behaviour.
module br_meta_stage
  import core_pkg::*;
#(
  parameter type T = meta_t
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic en,
  input  logic flush,
  input  logic d_vld,
  input  T     d,
  output logic vld,
  output T     q
);

  // flush wins even when the stage is held, so a squash is never lost to a stall.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld <= 1'b0;
      q   <= '0;
    end else begin
      if (flush) begin
        vld <= 1'b0;
      end else if (en) begin
        vld <= d_vld;
      end
      if (en) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves control transfers in EX against the prediction made at fetch,
// drives the registered predictor update / redirect and the perf counters.
module branch_resolve #(
  parameter int XLEN      = core_pkg::XLEN,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 if_vld,
  input  logic                 if_freeze,
  input  logic [XLEN-1:0]      if_pc,
  input  logic [XLEN-1:0]      bp_pc,
  input  logic                 bp_taken,
  input  logic                 id_stall,
  input  logic                 ex_stall,
  input  logic                 ex_br,
  input  logic                 ex_jal,
  input  logic                 ex_jalr,
  input  logic                 ex_cond,
  input  logic [XLEN-1:0]      ex_target,
  input  logic [4:0]           ex_rd,
  input  logic [4:0]           ex_rs1,
  output logic                 alu_branch,
  output logic                 alu_call,
  output logic                 alu_return,
  output logic                 alu_taken,
  output logic                 alu_flush,
  output logic [XLEN-1:0]      alu_pc,
  output logic [XLEN-1:0]      alu_target,
  output logic [XLEN-1:0]      redirect_pc,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] br_cnt,
  output logic [CNT_WIDTH-1:0] mis_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } stage_meta_t;

  stage_meta_t if_meta, meta_id, meta_ex;
  logic        vld_id, vld_ex;

  logic            ctl, act_taken, mis, is_call, is_ret;
  logic            rd_link, rs1_link;
  logic [XLEN-1:0] redirect_next;

  assign if_meta = '{pc: if_pc, taken: bp_taken, target: bp_pc};

  br_meta_stage #(.T(stage_meta_t)) u_id (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .en    (~id_stall),
    .flush (mis),
    .d_vld (if_vld & ~if_freeze & ~alu_flush),
    .d     (if_meta),
    .vld   (vld_id),
    .q     (meta_id)
  );

  // While ID stalls and EX advances, EX takes a bubble.
  br_meta_stage #(.T(stage_meta_t)) u_ex (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .en    (~ex_stall),
    .flush (mis),
    .d_vld (vld_id & ~id_stall),
    .d     (meta_id),
    .vld   (vld_ex),
    .q     (meta_ex)
  );

  assign ctl       = vld_ex & ~ex_stall & (ex_br | ex_jal | ex_jalr);
  assign act_taken = ex_jal | ex_jalr | (ex_br & ex_cond);
  assign mis       = ctl & ((act_taken != meta_ex.taken) |
                            (act_taken & meta_ex.taken & (ex_target != meta_ex.target)));

  assign rd_link  = core_pkg::is_link(ex_rd);
  assign rs1_link = core_pkg::is_link(ex_rs1);
  assign is_call  = (ex_jal | ex_jalr) & rd_link;
  // rd == rs1 both link registers is a coroutine swap: push only, no pop.
  assign is_ret   = ex_jalr & rs1_link & ~(rd_link & (ex_rd == ex_rs1));

  assign redirect_next = act_taken ? ex_target : meta_ex.pc + XLEN'(4);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      alu_branch  <= 1'b0;
      alu_call    <= 1'b0;
      alu_return  <= 1'b0;
      alu_taken   <= 1'b0;
      alu_flush   <= 1'b0;
      alu_pc      <= '0;
      alu_target  <= '0;
      redirect_pc <= '0;
    end else begin
      alu_branch  <= ctl;
      alu_call    <= ctl & is_call;
      alu_return  <= ctl & is_ret;
      alu_taken   <= ctl & act_taken;
      alu_flush   <= mis;
      alu_pc      <= ctl ? meta_ex.pc : '0;
      alu_target  <= ctl ? ex_target : '0;
      redirect_pc <= mis ? redirect_next : '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (cnt_clr) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (ctl && !(&br_cnt)) begin
        br_cnt <= br_cnt + CNT_WIDTH'(1);
      end
      if (mis && !(&mis_cnt)) begin
        mis_cnt <= mis_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
